opb_swreg_bank: RTL

OPB slave holding a bank of 32-bit software registers. It sits directly downstream of the EPB-to-OPB bridge on the shared OPB segment. It decodes the bridge's single-beat read/write transfers and returns a single-cycle `Sl_xferAck` or `Sl_errAck` after a programmable number of wait states. It exposes the registers to user fabric as parallel buses with per-register write and read strobes.

---
 rtl/opb_swreg_pkg.sv | 19 +
 rtl/opb_swreg_cell.sv | 31 +++
 rtl/opb_swreg_bank.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/opb_swreg_pkg.sv
// Shared types and helpers for the OPB software register bank.
package opb_swreg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam int unsigned WAIT_W = 4;

  // Index width for n registers, never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/opb_swreg_cell.sv
// One 32-bit software register with per-byte write enables.
module opb_swreg_cell #(
  parameter logic [31:0] C_RST_VAL = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wr_en_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] q_o
);

  logic [31:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) data_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) data_q <= C_RST_VAL;
    else          data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/opb_swreg_bank.sv
// OPB slave exposing a bank of 32-bit software registers to user fabric.
//   state | meaning
//   IDLE  | waiting for a hit; latches the transfer
//   WAIT  | counting wait states, timeout suppressed; select drop aborts
//   ACK   | decide xfer/err, commit write; acks appear registered next cycle
//   HOLD  | ack cycle; select ignored while the master releases it
module opb_swreg_bank #(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_FFFF,
  parameter int          C_NUM_REGS = 8,
  parameter logic [63:0] C_RO_MASK  = 64'h0,
  parameter int          C_WAIT     = 1,
  parameter logic [31:0] C_RST_VAL  = 32'h0
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [31:0]               OPB_ABus,
  input  logic [3:0]                OPB_BE,
  input  logic [31:0]               OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [31:0]               Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_toutSup,
  output logic                      Sl_retry,
  output logic [32*C_NUM_REGS-1:0]  reg_out,
  input  logic [32*C_NUM_REGS-1:0]  reg_in,
  output logic [C_NUM_REGS-1:0]     reg_wr_stb,
  output logic [C_NUM_REGS-1:0]     reg_rd_stb
);

  import opb_swreg_pkg::*;

  localparam int              IW        = idx_width(C_NUM_REGS);
  localparam logic [31:0]     SPAN      = C_HIGHADDR - C_BASEADDR;
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (C_WAIT == 0) ? '0 : WAIT_W'(C_WAIT - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  logic               latch;

  logic [31:0]        addr_q, wdata_q;
  logic [3:0]         be_q;
  logic               rnw_q;

  logic [31:0]        bus_off, lat_off;
  logic               hit, in_range, ro_sel, err, commit, wr_acc, rd_acc;
  logic [IW-1:0]      idx;
  logic [31:0]        rdata;
  logic [C_NUM_REGS-1:0] wr_stb_d, rd_stb_d, wr_stb_q, rd_stb_q;
  logic               xfer_q, err_q, tout_q;
  logic [31:0]        dbus_q;
  logic [32*C_NUM_REGS-1:0] cell_q;
  logic               unused_in;

  // Offset compare covers both bounds: addresses below base wrap past SPAN.
  assign bus_off = OPB_ABus - C_BASEADDR;
  assign hit     = OPB_select && (bus_off <= SPAN);

  assign lat_off  = addr_q - C_BASEADDR;
  assign in_range = (lat_off >> 2) < 32'(C_NUM_REGS);
  assign idx      = IW'(lat_off >> 2);
  assign ro_sel   = C_RO_MASK[idx];
  assign err      = !in_range || (!rnw_q && (ro_sel || be_q == 4'b0000));
  assign commit   = (state_q == ST_ACK);
  assign wr_acc   = commit && !err && !rnw_q;
  assign rd_acc   = commit && !err && rnw_q;

  always_comb begin
    rdata    = '0;
    wr_stb_d = '0;
    rd_stb_d = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx == IW'(i)) begin
        rdata       = C_RO_MASK[i] ? reg_in[32*i +: 32] : cell_q[32*i +: 32];
        wr_stb_d[i] = wr_acc;
        rd_stb_d[i] = rd_acc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          latch   = 1'b1;
          cnt_d   = WAIT_LOAD;
          state_d = (C_WAIT == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!OPB_select)       state_d = ST_IDLE;
        else if (cnt_q == '0)  state_d = ST_ACK;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rnw_q    <= 1'b0;
      xfer_q   <= 1'b0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
      dbus_q   <= '0;
      wr_stb_q <= '0;
      rd_stb_q <= '0;
    end else begin
      if (latch) begin
        addr_q  <= OPB_ABus;
        wdata_q <= OPB_DBus;
        be_q    <= OPB_BE;
        rnw_q   <= OPB_RNW;
      end
      xfer_q   <= commit && !err;
      err_q    <= commit && err;
      tout_q   <= (state_d == ST_WAIT);
      dbus_q   <= rd_acc ? rdata : '0;
      wr_stb_q <= wr_stb_d;
      rd_stb_q <= rd_stb_d;
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg
    opb_swreg_cell #(.C_RST_VAL(C_RST_VAL)) u_cell (
      .clk_i   (OPB_Clk),
      .rst_n_i (OPB_Rst_n),
      .wr_en_i (wr_stb_d[g]),
      .be_i    (be_q),
      .wdata_i (wdata_q),
      .q_o     (cell_q[32*g +: 32])
    );
  end

  // Burst hint is deliberately unused; reg_in lanes of writable registers too.
  assign unused_in = ^{OPB_seqAddr, reg_in};

  assign reg_out    = cell_q;
  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = xfer_q;
  assign Sl_errAck  = err_q;
  assign Sl_toutSup = tout_q;
  assign Sl_retry   = 1'b0;
  assign reg_wr_stb = wr_stb_q;
  assign reg_rd_stb = rd_stb_q;

endmodule
